// File: rtl/gray_fb_pkg.sv
// Shared constants and types for the time-slot (ruler-sequence) serial deserializer.
package gray_fb_pkg;

    localparam int unsigned WDefault    = 10;
    localparam int unsigned CntWDefault = WDefault + 1;
    localparam int unsigned LatMax      = 3;
    localparam int unsigned SlotIdxW    = 8;  // wide enough for W up to 256

    typedef logic [SlotIdxW-1:0] slot_idx_t;

    typedef struct packed {
        slot_idx_t idx;
        logic      valid;
        logic      frame_end;
    } slot_tag_t;

    function automatic int unsigned cnt_width(input int unsigned w);
        return w + 1;
    endfunction

endpackage

// File: rtl/gray_slot_decode.sv
// Combinational slot decoder: the slot of count n is ctz(n)-1; odd n and n=0 carry no slot.
module gray_slot_decode
    import gray_fb_pkg::*;
#(
    parameter int unsigned CntW = CntWDefault
) (
    input  logic [CntW-1:0] cnt_i,
    output slot_idx_t       slot_o,
    output logic            slot_valid_o,
    output logic            frame_end_o
);

    always_comb begin
        slot_o = '0;
        // Descending scan so the lowest set bit above bit 0 wins.
        for (int i = CntW - 1; i >= 1; i--) begin
            if (cnt_i[i]) begin
                slot_o = slot_idx_t'(i - 1);
            end
        end
        slot_valid_o = ~cnt_i[0] & (|cnt_i);
        frame_end_o  = &cnt_i;
    end

endmodule

// File: rtl/gray_deserializer_fb.sv
// Slot-multiplexed serial-to-parallel deserializer with frame lock.
// Optional change/direction flags are built when GRAY_DESER_CHANGE_EN is defined.
module gray_deserializer_fb
    import gray_fb_pkg::*;
#(
    parameter int unsigned W   = WDefault,
    parameter int unsigned LAT = 1
) (
    input  logic         clk_ext,
    input  logic         rst_ext,
    input  logic         sync,
    input  logic         serial_in,
    output logic [W-1:0] word,
    output logic         word_valid,
`ifdef GRAY_DESER_CHANGE_EN
    output logic         locked,
    output logic         change,
    output logic         dir_up
`else
    output logic         locked
`endif
);

    localparam int unsigned CntW   = cnt_width(W);
    // Out-of-range latency clamps to the deepest supported pipeline.
    localparam int unsigned LatEff = (LAT > LatMax) ? LatMax : LAT;

    logic [CntW-1:0] cnt_q, cnt_d;
    slot_idx_t       dec_idx;
    logic            dec_valid;
    logic            dec_end;
    slot_tag_t       tag_now;
    slot_tag_t       tag_pipe;

    gray_slot_decode #(
        .CntW(CntW)
    ) u_slot_decode (
        .cnt_i        (cnt_q),
        .slot_o       (dec_idx),
        .slot_valid_o (dec_valid),
        .frame_end_o  (dec_end)
    );

    assign tag_now = '{idx: dec_idx, valid: dec_valid, frame_end: dec_end};

    if (LatEff == 0) begin : g_no_pipe
        assign tag_pipe = tag_now;
    end else begin : g_pipe
        slot_tag_t pipe_q [LatEff];

        always_ff @(posedge clk_ext) begin
            if (rst_ext || sync) begin
                for (int i = 0; i < LatEff; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                pipe_q[0] <= tag_now;
                for (int i = 1; i < LatEff; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign tag_pipe = pipe_q[LatEff-1];
    end

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] word_q, word_d;
    logic         valid_q, valid_d;
    logic         locked_q, locked_d;

    always_comb begin
        cnt_d    = cnt_q + CntW'(1);
        shadow_d = shadow_q;
        word_d   = word_q;
        valid_d  = 1'b0;
        locked_d = locked_q;
        if (tag_pipe.valid) begin
            for (int j = 0; j < W; j++) begin
                if (tag_pipe.idx == slot_idx_t'(j)) begin
                    shadow_d[j] = serial_in;
                end
            end
        end
        if (tag_pipe.frame_end) begin
            word_d   = shadow_q;
            valid_d  = 1'b1;
            locked_d = 1'b1;
        end
        // Sync aborts the running frame but keeps the last delivered word.
        if (sync) begin
            cnt_d    = '0;
            shadow_d = '0;
            word_d   = word_q;
            valid_d  = 1'b0;
            locked_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            cnt_q    <= '0;
            shadow_q <= '0;
            word_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
        end
    end

    assign word       = word_q;
    assign word_valid = valid_q;
    assign locked     = locked_q;

`ifdef GRAY_DESER_CHANGE_EN
    logic change_q, change_d;
    logic dir_up_q, dir_up_d;

    always_comb begin
        change_d = 1'b0;
        dir_up_d = 1'b0;
        // The first word after lock has no predecessor to compare against.
        if (tag_pipe.frame_end && locked_q && !sync) begin
            change_d = (shadow_q != word_q);
            dir_up_d = (shadow_q > word_q);
        end
    end

    always_ff @(posedge clk_ext) begin
        if (rst_ext) begin
            change_q <= 1'b0;
            dir_up_q <= 1'b0;
        end else begin
            change_q <= change_d;
            dir_up_q <= dir_up_d;
        end
    end

    assign change = change_q;
    assign dir_up = dir_up_q;
`endif

endmodule
